td4_clk_gen: RTL and testbench
==============================

# td4_clk_gen

TD4 CPU clock-enable generator: the downstream consumer of the debounced push-button output of the chatter filter. Produces a single-cycle `CPU_EN` pulse that advances the TD4 core, either manually (one pulse per debounced button press) or automatically at a slow or fast divided rate. It also drives a visible clock LED and reports the active mode. The block sits between the chatter filter and the TD4 core in the CLK directory.

## Interface

- `DIV_SLOW`, default 1000000: CLK cycles per slow-run tick (1 Hz at 1 MHz CLK); must be ≥ 2.
- `DIV_FAST`, default 100000: CLK cycles per fast-run tick (10 Hz); must satisfy 2 ≤ `DIV_FAST` < `DIV_SLOW`.
- `REPEAT_DLY`, default 500000: CLK cycles the button is held before auto-repeat starts. Used only with `CLK_GEN_REPEAT_EN`.
- `CLK`  in  1  system clock; the only clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `STEP_I`  in  1  debounced step button (chatter filter `SW_O`); synchronous to `CLK`; 1 = pressed.
- `MODE_I`  in  2  00 manual, 01 slow run, 10 fast run, 11 halt.
- `CPU_EN`  out  1  one-cycle clock-enable to the TD4 core.
- `CLK_LED`  out  1  toggles on every `CPU_EN` pulse.
- `MODE_O`  out  2  currently applied mode.

## Operation

- State register `mode_q` has four states: MANUAL, SLOW, FAST, HALT. It loads from `MODE_I` on any cycle where `MODE_I != mode_q`.
- Divider counter `cnt` has width `$clog2(DIV_SLOW)`. It counts 0..limit-1 and wraps to 0. The limit is `DIV_SLOW` in SLOW and `DIV_FAST` in FAST.
- SLOW/FAST: `CPU_EN` = 1 for exactly the cycle after the edge where `cnt` wraps from limit-1 to 0.
- MANUAL: `cnt` is held at 0. A `STEP_I` rising edge is detected against the registered copy `step_q`. The registered `CPU_EN` goes high for one cycle per edge; holding the button produces no further pulses.
- HALT: `cnt` is held at 0, `CPU_EN` = 0, and `STEP_I` is ignored. `step_q` keeps tracking `STEP_I`.
- Mode change: on the cycle `mode_q` updates, `cnt` is cleared and no `CPU_EN` is issued. The first run tick then comes a full period after the change, and no partial period is ever emitted.
- Simultaneous mode change and step edge: the mode change wins and no pulse is issued. `step_q` still updates, so the edge is consumed.
- `CLK_LED` toggles on the edge that raises `CPU_EN`.

## Timing

- All outputs are registered.
- Reset values:
  - `CPU_EN` = 0, `CLK_LED` = 0, `MODE_O` = 00 (MANUAL).
  - `cnt` = 0.
  - `step_q` = 1, so a button held through reset produces no pulse.
- Manual latency: if `STEP_I` is first sampled 1 at edge k (with `step_q` = 0), `CPU_EN` is high from edge k to edge k+1.
- Run period: exactly limit cycles between consecutive `CPU_EN` rising edges. The first pulse comes limit+1 cycles after the edge that applied the mode.
- `MODE_O` follows `MODE_I` with 1 cycle of latency.
- Reset asserted mid-period: everything returns to reset values immediately (asynchronously). After release, operation restarts in MANUAL with `cnt` = 0.
- Minimum `CPU_EN` spacing is 2 cycles in every mode, so the core never sees back-to-back enables.

## Configuration

- `CLK_GEN_REPEAT_EN` defined:
  - In MANUAL, a hold counter starts when `STEP_I` rises and clears when `STEP_I` = 0.
  - After `STEP_I` has been high for `REPEAT_DLY` cycles past the initial pulse, `CPU_EN` repeats at the `DIV_SLOW` rate until release.
  - Releasing the button cancels any pending repeat with no trailing pulse.
  - Leaving MANUAL clears the hold counter.
- Not defined: no hold counter and no `REPEAT_DLY` logic. One pulse per press only.

## Test plan

Bench parameters: `DIV_SLOW`=10, `DIV_FAST`=4, `REPEAT_DLY`=6.

- Reset with `STEP_I`=1 held, release `RST_N`, keep `STEP_I`=1 for 20 cycles → `CPU_EN` stays 0, `CLK_LED`=0, `MODE_O`=00.
- MANUAL: 3 presses of 5 cycles high / 5 cycles low → exactly 3 one-cycle `CPU_EN` pulses, each in the cycle after `STEP_I` is first sampled high; `CLK_LED` ends at 1.
- `MODE_I`=01 for 45 cycles → first pulse 11 cycles after the mode edge, then every 10 cycles, 4 pulses total. Switch to 10 → no pulse on the change cycle, then a pulse every 4 cycles.
- `MODE_I`=11 with `STEP_I` toggling every 3 cycles → no `CPU_EN`. Return to 00 → the next `STEP_I` rising edge gives one pulse.
- Mode change from 00 to 01 in the same cycle as a `STEP_I` rising edge → no pulse that cycle; the next pulse follows the SLOW schedule. Assert `RST_N`=0 at `cnt`=7 → `CPU_EN`, `CLK_LED`, `MODE_O` are 0 immediately.
- With `CLK_GEN_REPEAT_EN`: hold `STEP_I`=1 for 40 cycles in MANUAL → initial pulse, next pulse 6+10 cycles later, then every 10 cycles until release, with none after release. Without the macro → a single pulse.

Source files
------------

// File: rtl/td4_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : td4_clk_gen                                                  |
// | Description : TD4 CPU clock-enable generator. Issues a one-cycle CPU_EN    |
// |               pulse per debounced button press (MANUAL) or at a divided    |
// |               rate (SLOW / FAST). HALT suppresses all pulses. CLK_LED      |
// |               toggles with every pulse and MODE_O reports the active mode. |
// |               Optional macro CLK_GEN_REPEAT_EN adds button auto-repeat     |
// |               in MANUAL after REPEAT_DLY cycles of hold.                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module td4_clk_gen #(
  parameter int DIV_SLOW   = 1000000,
  parameter int DIV_FAST   = 100000,
  parameter int REPEAT_DLY = 500000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       STEP_I,
  input  logic [1:0] MODE_I,
  output logic       CPU_EN,
  output logic       CLK_LED,
  output logic [1:0] MODE_O
);

  localparam int CNT_W = $clog2(DIV_SLOW);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(DIV_FAST - 1);

  // Reject divider settings that would break the two-cycle minimum pulse spacing.
  if (DIV_FAST < 2 || DIV_FAST >= DIV_SLOW || REPEAT_DLY < 1) begin : g_param_check
    $error("td4_clk_gen: illegal DIV_SLOW / DIV_FAST / REPEAT_DLY setting");
  end

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    SLOW   = 2'b01,
    FAST   = 2'b10,
    HALT   = 2'b11
  } mode_t;

  mode_t            mode_q;
  mode_t            mode_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] run_last;
  logic             step_q;
  logic             tick_q;   // divider wrapped on the previous edge
  logic             tick_d;
  logic             en_d;
  logic             mode_chg;
  logic             step_rise;
  logic             rep_fire;

`ifdef CLK_GEN_REPEAT_EN
  // Hold counter runs REPEAT_DLY cycles of delay, then DIV_SLOW-cycle repeat periods.
  localparam int HOLD_W = $clog2(REPEAT_DLY + DIV_SLOW);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DLY + DIV_SLOW - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DLY);

  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_d;

  // Advance the hold counter only while the button stays pressed in a stable MANUAL mode.
  always_comb begin
    hold_d   = '0;
    rep_fire = 1'b0;
    if (!mode_chg && mode_q == MANUAL && STEP_I && step_q) begin
      if (hold == HOLD_LAST) begin
        rep_fire = 1'b1;
        hold_d   = HOLD_RELOAD;
      end else begin
        hold_d = hold + 1'b1;
      end
    end
  end

  // Hold counter register; release or leaving MANUAL drops it back to zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold <= '0;
    end else begin
      hold <= hold_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Next mode, divider and enable decisions; a mode change suppresses any pulse.
  always_comb begin
    mode_d    = mode_t'(MODE_I);
    mode_chg  = (mode_d != mode_q);
    step_rise = STEP_I & ~step_q;
    run_last  = (mode_q == FAST) ? FAST_LAST : SLOW_LAST;
    cnt_d     = '0;
    tick_d    = 1'b0;
    en_d      = 1'b0;
    if (!mode_chg) begin
      if (mode_q == SLOW || mode_q == FAST) begin
        tick_d = (cnt == run_last);
        cnt_d  = tick_d ? '0 : cnt + 1'b1;
        en_d   = tick_q;
      end else if (mode_q == MANUAL) begin
        en_d = step_rise | rep_fire;
      end
    end
  end

  // State register and registered outputs; step_q resets high so a held button is not a press.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q  <= MANUAL;
      cnt     <= '0;
      step_q  <= 1'b1;
      tick_q  <= 1'b0;
      CPU_EN  <= 1'b0;
      CLK_LED <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cnt     <= cnt_d;
      step_q  <= STEP_I;
      tick_q  <= tick_d;
      CPU_EN  <= en_d;
      CLK_LED <= CLK_LED ^ en_d;
    end
  end

  assign MODE_O = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_td4_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_td4_clk_gen                                               |
// | Description : Directed self-checking bench for td4_clk_gen with            |
// |               DIV_SLOW=10, DIV_FAST=4, REPEAT_DLY=6.                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_td4_clk_gen;

  localparam int DIV_SLOW   = 10;
  localparam int DIV_FAST   = 4;
  localparam int REPEAT_DLY = 6;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       STEP_I;
  logic [1:0] MODE_I;
  logic       CPU_EN;
  logic       CLK_LED;
  logic [1:0] MODE_O;

  int   n_cmp   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  int   b2b     = 0;
  logic prev_en = 1'b0;
  int   pulse_cyc[$];

  td4_clk_gen #(
    .DIV_SLOW  (DIV_SLOW),
    .DIV_FAST  (DIV_FAST),
    .REPEAT_DLY(REPEAT_DLY)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .STEP_I (STEP_I),
    .MODE_I (MODE_I),
    .CPU_EN (CPU_EN),
    .CLK_LED(CLK_LED),
    .MODE_O (MODE_O)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it and pulses are logged.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (CPU_EN === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (prev_en) b2b++;
    end
    prev_en = (CPU_EN === 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offset of the i-th logged pulse from a reference cycle, -1 when absent.
  function automatic int offs(input int i, input int base);
    if (pulse_cyc.size() > i) return pulse_cyc[i] - base;
    return -1;
  endfunction

  initial begin
    int base;

    // Reset with the button held through it.
    RST_N  = 1'b0;
    STEP_I = 1'b1;
    MODE_I = 2'b00;
    ticks(3);
    check("rst_cpu_en", CPU_EN, 0);
    check("rst_clk_led", CLK_LED, 0);
    check("rst_mode_o", MODE_O, 0);
    RST_N = 1'b1;
    pulse_cyc.delete();
    ticks(20);
    check("held_no_pulse", pulse_cyc.size(), 0);
    check("held_clk_led", CLK_LED, 0);
    check("held_mode_o", MODE_O, 0);

    // MANUAL: three presses, 5 high / 5 low.
    STEP_I = 1'b0;
    ticks(2);
    pulse_cyc.delete();
    for (int p = 0; p < 3; p++) begin
      STEP_I = 1'b1;
      tick();
      check("man_pulse", CPU_EN, 1);
      tick();
      check("man_width", CPU_EN, 0);
      ticks(3);
      STEP_I = 1'b0;
      ticks(5);
    end
    check("man_count", pulse_cyc.size(), 3);
    check("man_clk_led", CLK_LED, 1);

    // SLOW for 45 cycles: pulses at +11, +21, +31, +41.
    pulse_cyc.delete();
    MODE_I = 2'b01;
    tick();
    base = cyc;
    check("slow_chg_no_pulse", CPU_EN, 0);
    check("slow_mode_o", MODE_O, 1);
    ticks(44);
    check("slow_count", pulse_cyc.size(), 4);
    check("slow_first", offs(0, base), 11);
    check("slow_second", offs(1, base), 21);
    check("slow_fourth", offs(3, base), 41);
    check("slow_clk_led", CLK_LED, 1);

    // FAST: no pulse on the change, then +5, +9, +13.
    pulse_cyc.delete();
    MODE_I = 2'b10;
    tick();
    base = cyc;
    check("fast_chg_no_pulse", CPU_EN, 0);
    check("fast_mode_o", MODE_O, 2);
    ticks(16);
    check("fast_count", pulse_cyc.size(), 3);
    check("fast_first", offs(0, base), 5);
    check("fast_second", offs(1, base), 9);
    check("fast_third", offs(2, base), 13);
    check("fast_clk_led", CLK_LED, 0);

    // HALT entered right after a divider wrap, button toggling every 3 cycles.
    pulse_cyc.delete();
    MODE_I = 2'b11;
    tick();
    check("halt_mode_o", MODE_O, 3);
    for (int i = 0; i < 8; i++) begin
      STEP_I = ~STEP_I;
      ticks(3);
    end
    check("halt_no_pulse", pulse_cyc.size(), 0);

    // Back to MANUAL: next rising edge gives one pulse.
    MODE_I = 2'b00;
    tick();
    check("ret_mode_o", MODE_O, 0);
    ticks(2);
    STEP_I = 1'b1;
    tick();
    check("ret_pulse", CPU_EN, 1);
    ticks(3);
    STEP_I = 1'b0;
    ticks(2);
    check("ret_count", pulse_cyc.size(), 1);
    check("ret_clk_led", CLK_LED, 1);

    // Mode change and step edge together: the change wins, SLOW schedule follows.
    pulse_cyc.delete();
    MODE_I = 2'b01;
    STEP_I = 1'b1;
    tick();
    base = cyc;
    check("simul_no_pulse", CPU_EN, 0);
    check("simul_mode_o", MODE_O, 1);
    ticks(10);
    check("simul_quiet", pulse_cyc.size(), 0);
    tick();
    check("simul_slow_first", CPU_EN, 1);
    ticks(6);
    check("pre_rst_mode_o", MODE_O, 1);

    // Asynchronous reset mid-period (divider at 7).
    RST_N = 1'b0;
    #1;
    check("arst_cpu_en", CPU_EN, 0);
    check("arst_clk_led", CLK_LED, 0);
    check("arst_mode_o", MODE_O, 0);
    MODE_I = 2'b00;
    pulse_cyc.delete();
    tick();
    RST_N = 1'b1;
    ticks(5);
    check("post_rst_no_pulse", pulse_cyc.size(), 0);
    check("post_rst_mode_o", MODE_O, 0);

    // Long hold in MANUAL for 40 cycles, then release.
    STEP_I = 1'b0;
    ticks(2);
    pulse_cyc.delete();
    STEP_I = 1'b1;
    tick();
    base = cyc;
    check("hold_first", CPU_EN, 1);
    ticks(39);
    STEP_I = 1'b0;
    ticks(20);
`ifdef CLK_GEN_REPEAT_EN
    check("hold_count", pulse_cyc.size(), 4);
    check("hold_rep1", offs(1, base), 16);
    check("hold_rep2", offs(2, base), 26);
    check("hold_rep3", offs(3, base), 36);
`else
    check("hold_count", pulse_cyc.size(), 1);
`endif

    check("min_spacing", b2b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
